// File: rtl/car_pkg.sv
// Encodings shared by the vehicle state controller and the manual driving FSM.
// Holds power levels, vehicle states and power-FSM states; no logic, no backpressure.
package car_pkg;

    localparam logic POFF = 1'b0;
    localparam logic PON  = 1'b1;

    localparam logic [1:0] NSTART = 2'b00;
    localparam logic [1:0] START  = 2'b01;
    localparam logic [1:0] MOVING = 2'b10;

    typedef enum logic [1:0] {
        P_OFF      = 2'b00,
        P_ON       = 2'b01,
        P_WAIT_REL = 2'b10
    } pstate_e;

    function automatic logic state_legal(input logic [1:0] s);
        return s != 2'b11;
    endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer for a raw button plus a rising-edge pulse on the synced level.
// Level appears 2 cycles after the raw input; rise_o is a single-cycle pulse; no backpressure.
module btn_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic lvl_o,
    output logic rise_o
);

    logic [2:0] sh_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sh_q <= 3'b000;
        end else begin
            sh_q <= {sh_q[1:0], btn_i};
        end
    end

    assign lvl_o  = sh_q[1];
    assign rise_o = sh_q[1] & ~sh_q[2];

endmodule

// File: rtl/vehicle_state_ctrl.sv
// Power/state registers for the manual FSM: long-press power-on, button/idle power-off, mileage.
// Commits next_* one cycle after presentation; buttons add 2 cycles of sync latency; no backpressure.
module vehicle_state_ctrl
    import car_pkg::*;
#(
    parameter int unsigned PRESS_CYCLES = 100_000_000,
    parameter int unsigned IDLE_CYCLES  = 1_000_000_000,
    parameter int unsigned TICK_CYCLES  = 50_000_000,
    parameter int unsigned CNT_W        = 30,
    parameter int unsigned DIST_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              power_on_btn,
    input  logic              power_off_btn,
    input  logic              mode_en,
    input  logic              activity,
    input  logic              next_power,
    input  logic [1:0]        next_state,
    output logic              power,
    output logic [1:0]        state,
    output logic [DIST_W-1:0] mileage,
    output logic              state_err
);

    localparam logic [CNT_W-1:0] PRESS_LAST = CNT_W'(PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TICK_LAST  = CNT_W'(TICK_CYCLES - 1);

    logic on_lvl, on_rise_unused, off_lvl_unused, off_rise;

    btn_sync u_on_sync (
        .clk_i  (clk),
        .rst_ni (rst),
        .btn_i  (power_on_btn),
        .lvl_o  (on_lvl),
        .rise_o (on_rise_unused)
    );

    btn_sync u_off_sync (
        .clk_i  (clk),
        .rst_ni (rst),
        .btn_i  (power_off_btn),
        .lvl_o  (off_lvl_unused),
        .rise_o (off_rise)
    );

    pstate_e           pstate_q;
    logic              power_q, state_err_q;
    logic [1:0]        state_q;
    logic [CNT_W-1:0]  press_q, idle_q, idle_d, tick_q, tick_d;
    logic [DIST_W-1:0] mileage_q, mileage_d;

    logic exit_on, commit, illegal, state_chg;

    // Exit priority: off button, FSM power-down request, then idle timeout.
    assign exit_on   = (pstate_q == P_ON) &&
                       (off_rise || (mode_en && !next_power) || (idle_q == IDLE_LAST));
    assign commit    = (pstate_q == P_ON) && !exit_on && mode_en;
    assign illegal   = commit && !state_legal(next_state);
    assign state_chg = commit && !illegal && (next_state != state_q);

    always_comb begin
        idle_d = idle_q + CNT_W'(1);
        if (pstate_q != P_ON || exit_on || activity || state_chg || state_q == MOVING) begin
            idle_d = '0;
        end
    end

    always_comb begin
        tick_d    = '0;
        mileage_d = mileage_q;
        if (power_q == PON && state_q == MOVING) begin
            if (tick_q == TICK_LAST) begin
                if (mileage_q != {DIST_W{1'b1}}) begin
                    mileage_d = mileage_q + DIST_W'(1);
                end
            end else begin
                tick_d = tick_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_q    <= '0;
            tick_q    <= '0;
            mileage_q <= '0;
        end else begin
            idle_q    <= idle_d;
            tick_q    <= tick_d;
            mileage_q <= mileage_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pstate_q    <= P_OFF;
            power_q     <= POFF;
            state_q     <= NSTART;
            state_err_q <= 1'b0;
            press_q     <= '0;
        end else begin
            state_err_q <= illegal;
            case (pstate_q)
                P_OFF: begin
                    power_q <= POFF;
                    state_q <= NSTART;
                    if (!on_lvl) begin
                        press_q <= '0;
                    end else if (press_q == PRESS_LAST) begin
                        press_q  <= '0;
                        pstate_q <= P_ON;
                        power_q  <= PON;
                    end else begin
                        press_q <= press_q + CNT_W'(1);
                    end
                end
                P_ON: begin
                    press_q <= '0;
                    if (exit_on) begin
                        pstate_q <= P_WAIT_REL;
                        power_q  <= POFF;
                        state_q  <= NSTART;
                    end else if (commit && !illegal) begin
                        state_q <= next_state;
                    end
                end
                P_WAIT_REL: begin
                    press_q <= '0;
                    power_q <= POFF;
                    state_q <= NSTART;
                    if (!on_lvl) begin
                        pstate_q <= P_OFF;
                    end
                end
                default: begin
                    pstate_q <= P_OFF;
                    power_q  <= POFF;
                    state_q  <= NSTART;
                    press_q  <= '0;
                end
            endcase
        end
    end

    assign power     = power_q;
    assign state     = state_q;
    assign mileage   = mileage_q;
    assign state_err = state_err_q;

endmodule

// File: tb/tb_vehicle_state_ctrl.sv
// Directed-vector bench for vehicle_state_ctrl with a cycle-stamped expectation queue.
// Stimulus pushes expected outputs; a negedge monitor pops and compares them.
module tb_vehicle_state_ctrl;

    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          power_on_btn = 1'b0;
    logic          power_off_btn = 1'b0;
    logic          mode_en = 1'b0;
    logic          activity = 1'b0;
    logic          next_power = 1'b0;
    logic [1:0]    next_state = 2'b00;
    logic          power;
    logic [1:0]    state;
    logic [DW-1:0] mileage;
    logic          state_err;

    vehicle_state_ctrl #(
        .PRESS_CYCLES (4),
        .IDLE_CYCLES  (10),
        .TICK_CYCLES  (5),
        .CNT_W        (30),
        .DIST_W       (DW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .power_on_btn  (power_on_btn),
        .power_off_btn (power_off_btn),
        .mode_en       (mode_en),
        .activity      (activity),
        .next_power    (next_power),
        .next_state    (next_state),
        .power         (power),
        .state         (state),
        .mileage       (mileage),
        .state_err     (state_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int            cyc;
        logic          pw;
        logic [1:0]    st;
        logic [DW-1:0] mil;
        logic          err;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    cyc = 0;
    int    n_chk = 0;
    int    n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_out(input string nm, input logic pw, input logic [1:0] st,
                              input logic [DW-1:0] mil, input logic err);
        exp_t e;
        e.cyc = cyc;
        e.pw  = pw;
        e.st  = st;
        e.mil = mil;
        e.err = err;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    always @(negedge clk) begin
        exp_t  e;
        string nm;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_chk++;
            if (e.cyc != cyc || power !== e.pw || state !== e.st ||
                mileage !== e.mil || state_err !== e.err) begin
                n_fail++;
                $display("FAIL %s: got power=%0b state=%02b mileage=%0h err=%0b, want power=%0b state=%02b mileage=%0h err=%0b (cyc %0d/%0d)",
                         nm, power, state, mileage, state_err, e.pw, e.st, e.mil, e.err, cyc, e.cyc);
            end
        end
    end

    initial begin
        step(2);
        expect_out("reset", 1'b0, 2'b00, 4'h0, 1'b0);
        rst = 1'b1;
        step(1);

        // Three synced-high cycles: too short.
        power_on_btn = 1'b1;
        step(3);
        power_on_btn = 1'b0;
        step(4);
        expect_out("short_press", 1'b0, 2'b00, 4'h0, 1'b0);

        // Four synced-high cycles: power-on.
        power_on_btn = 1'b1;
        step(5);
        expect_out("press_3of4", 1'b0, 2'b00, 4'h0, 1'b0);
        step(1);
        expect_out("press_on", 1'b1, 2'b00, 4'h0, 1'b0);
        power_on_btn = 1'b0;
        activity = 1'b1;
        mode_en = 1'b1;
        next_power = 1'b1;
        next_state = 2'b01;
        step(1);
        expect_out("commit_start", 1'b1, 2'b01, 4'h0, 1'b0);
        next_state = 2'b10;
        step(1);
        expect_out("commit_moving", 1'b1, 2'b10, 4'h0, 1'b0);
        step(4);
        expect_out("tick_pre1", 1'b1, 2'b10, 4'h0, 1'b0);
        step(1);
        expect_out("tick_1", 1'b1, 2'b10, 4'h1, 1'b0);
        step(7);
        expect_out("moving_12", 1'b1, 2'b10, 4'h2, 1'b0);
        next_state = 2'b01;
        step(1);
        expect_out("back_start", 1'b1, 2'b01, 4'h2, 1'b0);
        next_state = 2'b10;
        step(1);
        step(4);
        expect_out("partial_discard", 1'b1, 2'b10, 4'h2, 1'b0);
        step(1);
        expect_out("tick_after_re", 1'b1, 2'b10, 4'h3, 1'b0);
        next_state = 2'b01;
        step(1);
        expect_out("start_again", 1'b1, 2'b01, 4'h3, 1'b0);

        // Idle timeout from START.
        activity = 1'b0;
        step(9);
        expect_out("idle_9", 1'b1, 2'b01, 4'h3, 1'b0);
        step(1);
        expect_out("idle_off", 1'b0, 2'b00, 4'h3, 1'b0);

        // Idle timeout restarted by an activity pulse.
        power_on_btn = 1'b1;
        step(6);
        expect_out("repower", 1'b1, 2'b00, 4'h3, 1'b0);
        power_on_btn = 1'b0;
        step(8);
        activity = 1'b1;
        step(1);
        activity = 1'b0;
        step(2);
        expect_out("idle_pulse_held", 1'b1, 2'b01, 4'h3, 1'b0);
        step(7);
        expect_out("idle_pulse_9", 1'b1, 2'b01, 4'h3, 1'b0);
        step(1);
        expect_out("idle_pulse_off", 1'b0, 2'b00, 4'h3, 1'b0);

        // Off button with on-button held; off edge beats commit to MOVING.
        power_on_btn = 1'b1;
        step(6);
        expect_out("repower2", 1'b1, 2'b00, 4'h3, 1'b0);
        activity = 1'b1;
        power_off_btn = 1'b1;
        next_state = 2'b01;
        step(2);
        expect_out("pre_off", 1'b1, 2'b01, 4'h3, 1'b0);
        next_state = 2'b10;
        step(1);
        expect_out("off_wins", 1'b0, 2'b00, 4'h3, 1'b0);
        power_off_btn = 1'b0;
        step(8);
        expect_out("held_no_repower", 1'b0, 2'b00, 4'h3, 1'b0);
        power_on_btn = 1'b0;
        step(3);
        power_on_btn = 1'b1;
        next_state = 2'b01;
        step(5);
        expect_out("rehold_3", 1'b0, 2'b00, 4'h3, 1'b0);
        step(1);
        expect_out("rehold_on", 1'b1, 2'b00, 4'h3, 1'b0);
        power_on_btn = 1'b0;

        // Illegal next_state and ignored power-down without mode_en.
        step(1);
        expect_out("err_pre", 1'b1, 2'b01, 4'h3, 1'b0);
        next_state = 2'b11;
        step(1);
        expect_out("err_pulse", 1'b1, 2'b01, 4'h3, 1'b1);
        next_state = 2'b01;
        step(1);
        expect_out("err_clear", 1'b1, 2'b01, 4'h3, 1'b0);
        mode_en = 1'b0;
        next_power = 1'b0;
        next_state = 2'b10;
        step(3);
        expect_out("mode_off_ignored", 1'b1, 2'b01, 4'h3, 1'b0);

        // Mileage saturation, then async reset mid-tick.
        mode_en = 1'b1;
        next_power = 1'b1;
        step(1);
        step(55);
        expect_out("mileage_E", 1'b1, 2'b10, 4'hE, 1'b0);
        step(5);
        expect_out("mileage_F", 1'b1, 2'b10, 4'hF, 1'b0);
        step(15);
        expect_out("mileage_sat", 1'b1, 2'b10, 4'hF, 1'b0);
        step(2);
        #2;
        rst = 1'b0;
        expect_out("async_reset", 1'b0, 2'b00, 4'h0, 1'b0);
        step(2);

        if (exp_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
